vec_element_sequencer: RTL and testbench

- Drives a single per-element vector ALU lane (elementA/elementB/opcode in, result out) from a full-width vector operation request.
- Each request is two LANES-element vectors plus an opcode. The block feeds one element pair per cycle to the ALU, collects the per-element results, and presents the assembled result vector on a valid/ready output.
- It sits between vector decode/register read and writeback, and is the issuing side of the element ALU interface.

---
 rtl/vec_element_sequencer.sv | 107 ++++++++++
 tb/tb_vec_element_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_element_sequencer.sv
// Vector element sequencer: accepts a full-width vector op, feeds one element
// pair per cycle to an external combinational element ALU, collects the
// per-element results and presents the assembled vector on a valid/ready port.
module vec_element_sequencer #(
   parameter int ELEMENT = 16,
   parameter int LANES   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*ELEMENT-1:0]   vec_a,
   input  logic [LANES*ELEMENT-1:0]   vec_b,
   input  logic [2:0]                 op,
   output logic [ELEMENT-1:0]         alu_a,
   output logic [ELEMENT-1:0]         alu_b,
   output logic [2:0]                 alu_opcode,
   input  logic [ELEMENT-1:0]         alu_result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*ELEMENT-1:0]   out_vec,
   output logic                       busy
);

   // A single lane still needs a one-bit index so the RUN compare is legal.
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                         state;
   logic [IW-1:0]                  idx;
   logic [LANES-1:0][ELEMENT-1:0]  a_reg;
   logic [LANES-1:0][ELEMENT-1:0]  b_reg;
   logic [LANES-1:0][ELEMENT-1:0]  res_reg;
   logic [2:0]                     op_reg;

   // Control FSM: latches operands, walks idx across the lanes, holds the
   // result until the consumer takes it. Handshake flags are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         op_reg    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= vec_a;
                  b_reg    <= vec_b;
                  op_reg   <= op;
                  idx      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               res_reg[idx] <= alu_result;
               if (idx == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  idx       <= '0;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               idx       <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   // ALU drive is the current lane while running, quiet zero otherwise.
   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_opcode = '0;
      if (state == RUN) begin
         alu_a      = a_reg[idx];
         alu_b      = b_reg[idx];
         alu_opcode = op_reg;
      end
   end

   assign out_vec = res_reg;

endmodule

// File: tb/tb_vec_element_sequencer.sv
// Scoreboard bench for vec_element_sequencer: a driver issues directed and
// random requests and pushes the model's expected vector; a monitor checks
// ALU drive, latency, hold under backpressure and the delivered vector.
module tb_vec_element_sequencer;
   localparam int ELEMENT = 16;
   localparam int LANES   = 8;
   localparam int W       = LANES * ELEMENT;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [W-1:0]       vec_a, vec_b;
   logic [2:0]         op;
   logic [ELEMENT-1:0] alu_a, alu_b, alu_result;
   logic [2:0]         alu_opcode;
   logic               out_valid;
   logic               out_ready;
   logic [W-1:0]       out_vec;
   logic               busy;

   always #5 clk = ~clk;

   vec_element_sequencer #(.ELEMENT(ELEMENT), .LANES(LANES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .vec_a(vec_a), .vec_b(vec_b), .op(op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      logic [2:0]   op;
      int           acc_cyc;
   } txn_t;

   txn_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic bp_mode = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Element ALU stand-in: 000 add, 011 xor, everything else unsupported -> 0.
   function automatic logic [ELEMENT-1:0] elem_op(input logic [ELEMENT-1:0] a,
                                                  input logic [ELEMENT-1:0] b,
                                                  input logic [2:0] o);
      case (o)
         3'b000:  return a + b;
         3'b011:  return a ^ b;
         default: return '0;
      endcase
   endfunction

   always_comb alu_result = elem_op(alu_a, alu_b, alu_opcode);

   // Reference: every result lane is the ALU applied to the matching operand lanes.
   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] o);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         r[i*ELEMENT +: ELEMENT] = elem_op(a[i*ELEMENT +: ELEMENT], b[i*ELEMENT +: ELEMENT], o);
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic tick();
      @(negedge clk);
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present a request, wait for acceptance, then record what should come back.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
      int n;
      txn_t t;
      in_valid = 1'b1;
      vec_a = a;
      vec_b = b;
      op = o;
      n = 0;
      while (!(in_ready === 1'b1 && rst === 1'b0) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) flag("accept_timeout");
      tick();
      in_valid = 1'b0;
      vec_a = W'($urandom);
      t.a = a;
      t.b = b;
      t.op = o;
      t.exp = model(a, b, o);
      t.acc_cyc = cyc;
      q.push_back(t);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) flag("drain_timeout");
   endtask

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Monitor: sampled mid-low-phase, after the driver has settled its inputs.
   initial begin
      int k;
      logic prev_ov;
      logic [W-1:0] hold;
      k = 0;
      prev_ov = 1'b0;
      hold = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst !== 1'b0) begin
            k = 0;
            prev_ov = 1'b0;
         end else begin
            if (!busy || out_valid) begin
               k = 0;
               check("alu_a_quiet", W'(alu_a), '0);
               check("alu_b_quiet", W'(alu_b), '0);
               check("alu_op_quiet", W'(alu_opcode), '0);
            end else if (q.size() == 0 || k >= LANES) begin
               flag("unexpected_run");
            end else begin
               check("alu_a_lane", W'(alu_a), W'(q[0].a[k*ELEMENT +: ELEMENT]));
               check("alu_b_lane", W'(alu_b), W'(q[0].b[k*ELEMENT +: ELEMENT]));
               check("alu_opcode", W'(alu_opcode), W'(q[0].op));
               k++;
            end
            if (out_valid) begin
               if (!prev_ov) begin
                  hold = out_vec;
                  if (q.size() > 0) check("latency", W'(cyc - q[0].acc_cyc), W'(LANES));
               end else begin
                  check("out_hold", out_vec, hold);
               end
               if (out_ready) begin
                  if (q.size() == 0) flag("unexpected_output");
                  else begin
                     check("out_vec", out_vec, q[0].exp);
                     void'(q.pop_front());
                  end
               end
            end
            prev_ov = out_valid;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a, b;
      int n;
      rst = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b0;
      vec_a = rand_vec();
      vec_b = rand_vec();
      op = 3'b000;
      // Reset held two edges with a competing request: reset must win.
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_busy", W'(busy), W'(0));
      check("rst_out_vec", out_vec, '0);
      check("rst_alu_a", W'(alu_a), '0);
      check("rst_alu_b", W'(alu_b), '0);
      check("rst_alu_opcode", W'(alu_opcode), '0);

      // Basic add: lane i = (i+1) + 0x100*i, lane 7 = 0x0708.
      out_ready = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         a[i*ELEMENT +: ELEMENT] = ELEMENT'(i + 1);
         b[i*ELEMENT +: ELEMENT] = ELEMENT'(16'h0100 * i);
      end
      check("add_lane7_model", W'(model(a, b, 3'b000) >> (7*ELEMENT)), W'(16'h0708));
      send(a, b, 3'b000);
      drain();

      // Wrap-around: every lane sums to 2^16 and lands on zero.
      for (int i = 0; i < LANES; i++) begin
         a[i*ELEMENT +: ELEMENT] = (i == 3) ? 16'h8000 : 16'hFFFF;
         b[i*ELEMENT +: ELEMENT] = (i == 3) ? 16'h8000 : 16'h0001;
      end
      send(a, b, 3'b000);
      drain();

      // Backpressure: hold the result for 5 cycles while new data knocks.
      out_ready = 1'b0;
      send(rand_vec(), rand_vec(), 3'b000);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) flag("bp_wait_valid");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         vec_a = rand_vec();
         vec_b = rand_vec();
         op = 3'b011;
         check("bp_in_ready", W'(in_ready), W'(0));
         check("bp_out_valid", W'(out_valid), W'(1));
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", W'(in_ready), W'(1));
      check("bp_release_out_valid", W'(out_valid), W'(0));
      send(rand_vec(), rand_vec(), 3'b011);
      drain();

      // Reset while idx=4: work discarded, then 2+3 on every lane.
      send(rand_vec(), rand_vec(), 3'b000);
      repeat (4) tick();
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0;
      check("midrst_out_valid", W'(out_valid), W'(0));
      check("midrst_out_vec", out_vec, '0);
      check("midrst_in_ready", W'(in_ready), W'(1));
      check("midrst_busy", W'(busy), W'(0));
      for (int i = 0; i < LANES; i++) begin
         a[i*ELEMENT +: ELEMENT] = 16'h0002;
         b[i*ELEMENT +: ELEMENT] = 16'h0003;
      end
      send(a, b, 3'b000);
      drain();

      // Unsupported opcode: zero result, normal latency.
      send(rand_vec(), rand_vec(), 3'b001);
      drain();

      // Random traffic with random consumer backpressure.
      bp_mode = 1'b1;
      for (int t = 0; t < 25; t++) begin
         logic [2:0] o;
         case ($urandom_range(0, 2))
            0:       o = 3'b000;
            1:       o = 3'b011;
            default: o = 3'($urandom);
         endcase
         send(rand_vec(), rand_vec(), o);
      end
      bp_mode = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
